// File: rtl/shift_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_unit_pipe
// Brief    : Two-stage valid/ready 32-bit shifter (ROL/LSL/LSR/ASR) with flags.
// Revision : 1.0
// ============================================================================
module shift_unit_pipe (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [4:0]  shift,
   input  logic [1:0]  op,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] OutA,
   output logic        carry,
   output logic        zero,
   output logic        neg
);

   localparam logic [1:0] c_OP_ROL = 2'b00;
   localparam logic [1:0] c_OP_LSL = 2'b01;
   localparam logic [1:0] c_OP_LSR = 2'b10;
   localparam logic [1:0] c_OP_ASR = 2'b11;

   logic        r_s1_valid;
   logic [31:0] r_s1_rot;
   logic [31:0] r_s1_a;
   logic [4:0]  r_s1_sh;
   logic [1:0]  r_s1_op;

   logic        r_s2_valid;
   logic [31:0] r_out;
   logic        r_carry;
   logic        r_zero;
   logic        r_neg;

   logic        w_s1_en;
   logic        w_s2_en;
   logic [63:0] w_rol_dbl;
   logic [63:0] w_ror_dbl;
   logic [31:0] w_ror;
   logic [31:0] w_lo_mask;
   logic [31:0] w_hi_mask;
   logic [4:0]  w_lsl_idx;
   logic [4:0]  w_lsr_idx;
   logic [31:0] w_res;
   logic        w_carry;

   // rst forces the enables high so in_ready reads 1 throughout reset.
   assign w_s2_en  = rst | ~r_s2_valid | out_ready;
   assign w_s1_en  = ~r_s1_valid | w_s2_en;
   assign in_ready = w_s1_en;

   assign w_rol_dbl = {A, A} << shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_s1_en) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_rot <= w_rol_dbl[63:32];
            r_s1_a   <= A;
            r_s1_sh  <= shift;
            r_s1_op  <= op;
         end
      end
   end

   // Right shifts reuse a rotate-right of the held operand, then mask the top.
   assign w_ror_dbl = {r_s1_a, r_s1_a} >> r_s1_sh;
   assign w_ror     = w_ror_dbl[31:0];
   assign w_lo_mask = (32'h0000_0001 << r_s1_sh) - 32'h0000_0001;
   assign w_hi_mask = ~(32'hFFFF_FFFF >> r_s1_sh);
   assign w_lsl_idx = 5'd0 - r_s1_sh;
   assign w_lsr_idx = r_s1_sh - 5'd1;

   always_comb begin
      w_res   = r_s1_rot;
      w_carry = 1'b0;
      case (r_s1_op)
         c_OP_ROL: begin
            w_res   = r_s1_rot;
            w_carry = r_s1_rot[0];
         end
         c_OP_LSL: begin
            w_res   = r_s1_rot & ~w_lo_mask;
            w_carry = r_s1_a[w_lsl_idx];
         end
         c_OP_LSR: begin
            w_res   = w_ror & ~w_hi_mask;
            w_carry = r_s1_a[w_lsr_idx];
         end
         c_OP_ASR: begin
            w_res   = (w_ror & ~w_hi_mask) | ({32{r_s1_a[31]}} & w_hi_mask);
            w_carry = r_s1_a[w_lsr_idx];
         end
         default: begin
            w_res   = r_s1_rot;
            w_carry = 1'b0;
         end
      endcase
      if (r_s1_sh == 5'd0) begin
         w_carry = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_out      <= 32'h0000_0000;
         r_carry    <= 1'b0;
         r_zero     <= 1'b0;
         r_neg      <= 1'b0;
      end else if (w_s2_en) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_out   <= w_res;
            r_carry <= w_carry;
            r_zero  <= (w_res == 32'h0000_0000);
            r_neg   <= w_res[31];
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign OutA      = r_out;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign neg       = r_neg;

endmodule
`default_nettype wire
